// File: rtl/life_manager_if.sv
// rtl/life_manager_if.sv - game-flow control bundle between the life manager and its neighbours
interface life_manager_if #(
    parameter int LIVES_W = 3
);
    logic               start;
    logic               died;
    logic               level_clear;
    logic [15:0]        score;
    logic [LIVES_W-1:0] lives;
    logic               freeze;
    logic               respawn;
    logic               game_over;
    logic               dying;
    logic [3:0]         death_frame;

    modport master (
        output start, died, level_clear, score,
        input  lives, freeze, respawn, game_over, dying, death_frame
    );

    modport slave (
        input  start, died, level_clear, score,
        output lives, freeze, respawn, game_over, dying, death_frame
    );
endinterface

// File: rtl/life_manager.sv
// rtl/life_manager.sv - lives/ready/death/game-over sequencer; EXTRA_LIFE_EN enables the one-shot score bonus life
module life_manager #(
    parameter int INIT_LIVES       = 3,
    parameter int LIVES_W          = 3,
    parameter int READY_FRAMES     = 120,
    parameter int ANIM_DIV         = 8,
    parameter int ANIM_FRAMES      = 12,
    parameter int EXTRA_LIFE_SCORE = 10000
) (
    input  logic          frame_clk,
    input  logic          reset,
    life_manager_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_PLAY,
        S_DYING,
        S_GAME_OVER
    } state_t;

    localparam int DYING_FRAMES = ANIM_DIV * ANIM_FRAMES;
    localparam int TIMER_MAX    = (READY_FRAMES > DYING_FRAMES) ? READY_FRAMES : DYING_FRAMES;
    localparam int TIMER_W      = $clog2(TIMER_MAX + 1);
    localparam int DIV_W        = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [LIVES_W-1:0] MAX_LIVES = '1;

    state_t               state;
    logic [LIVES_W-1:0]   lives_q;
    logic [LIVES_W-1:0]   lives_play;
    logic                 freeze_q;
    logic                 respawn_q;
    logic                 game_over_q;
    logic                 dying_q;
    logic [3:0]           frame_q;
    logic [TIMER_W-1:0]   timer;
    logic [DIV_W-1:0]     div_cnt;
    logic                 bonus_hit;

`ifdef EXTRA_LIFE_EN
    logic bonus_taken;
    assign bonus_hit = !bonus_taken && (bus.score >= 16'(EXTRA_LIFE_SCORE));
`else
    assign bonus_hit = 1'b0;
`endif

    // A bonus landing on the same edge as a death cancels it out
    always_comb begin
        lives_play = lives_q;
        if (bus.died && !bonus_hit) begin
            if (lives_q != '0) lives_play = lives_q - LIVES_W'(1);
        end else if (!bus.died && bonus_hit) begin
            if (lives_q != MAX_LIVES) lives_play = lives_q + LIVES_W'(1);
        end
    end

    always_ff @(posedge frame_clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            lives_q     <= LIVES_W'(INIT_LIVES);
            freeze_q    <= 1'b1;
            respawn_q   <= 1'b0;
            game_over_q <= 1'b0;
            dying_q     <= 1'b0;
            frame_q     <= 4'd0;
            timer       <= '0;
            div_cnt     <= '0;
`ifdef EXTRA_LIFE_EN
            bonus_taken <= 1'b0;
`endif
        end else begin
            respawn_q <= 1'b0;
            case (state)
                S_IDLE, S_GAME_OVER: begin
                    if (bus.start) begin
                        state       <= S_READY;
                        lives_q     <= LIVES_W'(INIT_LIVES);
                        respawn_q   <= 1'b1;
                        freeze_q    <= 1'b1;
                        game_over_q <= 1'b0;
                        timer       <= '0;
`ifdef EXTRA_LIFE_EN
                        bonus_taken <= 1'b0;
`endif
                    end
                end
                S_READY: begin
                    if (timer == TIMER_W'(READY_FRAMES - 1)) begin
                        state    <= S_PLAY;
                        freeze_q <= 1'b0;
                        timer    <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_PLAY: begin
                    lives_q <= lives_play;
`ifdef EXTRA_LIFE_EN
                    if (bonus_hit) bonus_taken <= 1'b1;
`endif
                    if (bus.died) begin
                        state    <= S_DYING;
                        freeze_q <= 1'b1;
                        dying_q  <= 1'b1;
                        timer    <= '0;
                        div_cnt  <= '0;
                        frame_q  <= 4'd0;
                    end else if (bus.level_clear) begin
                        state     <= S_READY;
                        freeze_q  <= 1'b1;
                        respawn_q <= 1'b1;
                        timer     <= '0;
                    end
                end
                S_DYING: begin
                    if (timer == TIMER_W'(DYING_FRAMES - 1)) begin
                        dying_q <= 1'b0;
                        timer   <= '0;
                        frame_q <= 4'd0;
                        if (lives_q == '0) begin
                            state       <= S_GAME_OVER;
                            game_over_q <= 1'b1;
                        end else begin
                            state     <= S_READY;
                            respawn_q <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                        // Animation step advances once per ANIM_DIV frames and parks on the last step
                        if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
                            div_cnt <= '0;
                            if (frame_q != 4'(ANIM_FRAMES - 1)) frame_q <= frame_q + 4'd1;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.lives       = lives_q;
    assign bus.freeze      = freeze_q;
    assign bus.respawn     = respawn_q;
    assign bus.game_over   = game_over_q;
    assign bus.dying       = dying_q;
    assign bus.death_frame = frame_q;
endmodule
